// File: rtl/conv2d_ctrl_pkg.sv
// conv2d_ctrl shared types: sequencer state encoding and counter sizing helper.
package conv2d_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } ctrl_state_e;

   // Bits needed to hold every value 0..count without wrapping.
   function automatic int unsigned cnt_width(input int unsigned count);
      return (count < 1) ? 1 : $clog2(count + 1);
   endfunction

endpackage

// File: rtl/conv2d_ctrl_if.sv
// conv2d_ctrl bus: start, weight stream, pixel pass-through, output snoop and status.
// slave = the controller, master = the surrounding frame logic.
interface conv2d_ctrl_if #(
   parameter int unsigned KernelArea  = 9,
   parameter int unsigned WeightWidth = 2
) ();

   logic                              start_i;
   logic                              cfg_valid_i;
   logic                              cfg_ready_o;
   logic [WeightWidth-1:0]            cfg_data_i;
   logic                              pix_valid_i;
   logic                              pix_ready_o;
   logic                              conv_valid_o;
   logic                              conv_ready_i;
   logic                              mon_valid_i;
   logic                              mon_ready_i;
   logic [KernelArea*WeightWidth-1:0] weights_o;
   logic                              busy_o;
   logic                              frame_done_o;
   logic                              err_o;

   modport slave (
      input  start_i, cfg_valid_i, cfg_data_i, pix_valid_i, conv_ready_i,
             mon_valid_i, mon_ready_i,
      output cfg_ready_o, pix_ready_o, conv_valid_o, weights_o, busy_o,
             frame_done_o, err_o
   );

   modport master (
      output start_i, cfg_valid_i, cfg_data_i, pix_valid_i, conv_ready_i,
             mon_valid_i, mon_ready_i,
      input  cfg_ready_o, pix_ready_o, conv_valid_o, weights_o, busy_o,
             frame_done_o, err_o
   );

endinterface

// File: rtl/weight_bank.sv
// Shadow/active kernel weight double buffer. The shadow fills one weight per
// accepted beat (index 0 first); a swap copies a full shadow into the active bank.
module weight_bank
   import conv2d_ctrl_pkg::*;
#(
   parameter int unsigned KernelArea  = 9,
   parameter int unsigned WeightWidth = 2
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              wr_valid_i,
   input  logic [WeightWidth-1:0]            wr_data_i,
   output logic                              wr_ready_o,
   input  logic                              swap_i,
   output logic [KernelArea*WeightWidth-1:0] weights_o,
   output logic                              shadow_full_o,
   output logic                              active_valid_o
);

   localparam int unsigned IdxW = cnt_width(KernelArea - 1);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(KernelArea - 1);

   logic [KernelArea-1:0][WeightWidth-1:0] shadow_q;
   logic [KernelArea-1:0][WeightWidth-1:0] active_q;
   logic [IdxW-1:0]                        idx_q;
   logic                                   full_q;
   logic                                   valid_q;
   logic                                   wr_fire;

   assign wr_ready_o     = ~full_q;
   assign wr_fire        = wr_valid_i & ~full_q;
   assign weights_o      = active_q;
   assign shadow_full_o  = full_q;
   assign active_valid_o = valid_q;

   // Shadow fill and shadow->active swap; ready is low while full, so the two never coincide.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shadow_q <= '0;
         active_q <= '0;
         idx_q    <= '0;
         full_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else if (wr_fire) begin
         shadow_q[idx_q] <= wr_data_i;
         if (idx_q == IdxLast) begin
            idx_q  <= '0;
            full_q <= 1'b1;
         end else begin
            idx_q <= idx_q + 1'b1;
         end
      end else if (swap_i && full_q) begin
         active_q <= shadow_q;
         full_q   <= 1'b0;
         valid_q  <= 1'b1;
      end
   end

endmodule

// File: rtl/conv2d_ctrl.sv
// conv2d frame sequencer: gates one frame of pixels per start into conv2d,
// counts conv2d outputs until the frame drains, and swaps kernel weights only
// between frames. Optional DRAIN watchdog: define CONV2D_CTRL_TIMEOUT_EN.
module conv2d_ctrl
   import conv2d_ctrl_pkg::*;
#(
   parameter int unsigned LineWidthPx  = 160,
   parameter int unsigned LineCountPx  = 120,
   parameter int unsigned KernelWidth  = 3,
   parameter int unsigned WeightWidth  = 2,
   parameter int unsigned DrainTimeout = 64
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   conv2d_ctrl_if.slave ctrl
);

   localparam int unsigned KernelArea = KernelWidth * KernelWidth;
   localparam int unsigned NumPix     = LineWidthPx * LineCountPx;
   localparam int unsigned NumOut     = (LineWidthPx - KernelWidth + 1) *
                                        (LineCountPx - KernelWidth + 1);
   localparam int unsigned InW        = cnt_width(NumPix);
   localparam int unsigned OutW       = cnt_width(NumOut);
   localparam logic [InW-1:0]  InLast   = InW'(NumPix - 1);
   localparam logic [OutW-1:0] OutTotal = OutW'(NumOut);

   if (KernelWidth > LineWidthPx || KernelWidth > LineCountPx || DrainTimeout == 0) begin : g_bad_cfg
      $error("conv2d_ctrl: kernel larger than frame or zero drain timeout");
   end

   ctrl_state_e      state_q, state_d;
   logic [InW-1:0]   in_cnt_q;
   logic [OutW-1:0]  out_cnt_q;
   logic             frame_done_q;
   logic             shadow_full, active_valid, swap;
   logic             in_fire, in_last, out_inc, drain_done, timeout_hit, frame_end;

   assign in_fire    = (state_q == RUN) & ctrl.pix_valid_i & ctrl.conv_ready_i;
   assign in_last    = in_fire & (in_cnt_q == InLast);
   assign out_inc    = ((state_q == RUN) | (state_q == DRAIN)) & ctrl.mon_valid_i &
                       ctrl.mon_ready_i & (out_cnt_q != OutTotal);
   assign drain_done = (state_q == DRAIN) & (out_cnt_q == OutTotal);
   assign frame_end  = drain_done | timeout_hit;

   weight_bank #(
      .KernelArea (KernelArea),
      .WeightWidth(WeightWidth)
   ) u_bank (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .wr_valid_i    (ctrl.cfg_valid_i),
      .wr_data_i     (ctrl.cfg_data_i),
      .wr_ready_o    (ctrl.cfg_ready_o),
      .swap_i        (swap),
      .weights_o     (ctrl.weights_o),
      .shadow_full_o (shadow_full),
      .active_valid_o(active_valid)
   );

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic; start is only honoured in IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (ctrl.start_i)                state_d = ARM;
         ARM:     if (active_valid | shadow_full)  state_d = RUN;
         RUN:     if (in_last)                     state_d = DRAIN;
         DRAIN:   if (frame_end)                   state_d = IDLE;
         default:                                  state_d = IDLE;
      endcase
   end

   // Outputs: pixel path is a combinational pass-through only while in RUN.
   always_comb begin
      ctrl.pix_ready_o  = 1'b0;
      ctrl.conv_valid_o = 1'b0;
      ctrl.busy_o       = (state_q != IDLE);
      swap              = 1'b0;
      case (state_q)
         ARM: swap = shadow_full;
         RUN: begin
            ctrl.pix_ready_o  = ctrl.conv_ready_i;
            ctrl.conv_valid_o = ctrl.pix_valid_i;
         end
         default: ;
      endcase
   end

   // Frame input/output counters and the registered completion pulse.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         in_cnt_q     <= '0;
         out_cnt_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= frame_end;
         if (frame_end) begin
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
         end else begin
            if (in_fire) in_cnt_q  <= in_cnt_q + 1'b1;
            if (out_inc) out_cnt_q <= out_cnt_q + 1'b1;
         end
      end
   end

   assign ctrl.frame_done_o = frame_done_q;

`ifdef CONV2D_CTRL_TIMEOUT_EN
   localparam int unsigned WdW = cnt_width(DrainTimeout);
   localparam logic [WdW-1:0] WdLast = WdW'(DrainTimeout - 1);

   logic [WdW-1:0] wd_q;
   logic           err_q;

   // Watchdog: consecutive DRAIN cycles without an output count.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                              wd_q <= '0;
      else if ((state_q != DRAIN) || out_inc)   wd_q <= '0;
      else if (wd_q != WdLast)                  wd_q <= wd_q + 1'b1;
   end

   assign timeout_hit = (state_q == DRAIN) & ~out_inc & ~drain_done & (wd_q == WdLast);

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)          err_q <= 1'b0;
      else if (timeout_hit) err_q <= 1'b1;
   end

   assign ctrl.err_o = err_q;
`else
   assign timeout_hit = 1'b0;
   assign ctrl.err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_conv2d_ctrl.sv
// Directed bench for conv2d_ctrl on a 5x4 frame with a 3x3 kernel
// (20 pixels in, 6 conv outputs per frame).
module tb_conv2d_ctrl;

   localparam int unsigned LW = 5;
   localparam int unsigned LC = 4;
   localparam int unsigned KW = 3;
   localparam int unsigned WW = 2;
   localparam int unsigned KA = KW * KW;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   conv2d_ctrl_if #(.KernelArea(KA), .WeightWidth(WW)) bus ();

   conv2d_ctrl #(
      .LineWidthPx (LW),
      .LineCountPx (LC),
      .KernelWidth (KW),
      .WeightWidth (WW),
      .DrainTimeout(64)
   ) dut (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .ctrl  (bus)
   );

   int errors = 0;
   int checks = 0;

   logic [17:0] wa, wb;
   int          sent;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [17:0] pattern(input bit inv);
      logic [17:0] p;
      p = '0;
      for (int k = 0; k < 9; k++)
         p[k*2 +: 2] = inv ? 2'(3 - (k % 4)) : 2'(k % 4);
      return p;
   endfunction

   // Push nine weights through the cfg handshake.
   task automatic load_weights(input logic [17:0] w);
      int k;
      int cyc;
      k   = 0;
      cyc = 0;
      while (k < 9 && cyc < 50) begin
         bus.cfg_valid_i = 1'b1;
         bus.cfg_data_i  = w[k*2 +: 2];
         #1;
         if (bus.cfg_ready_o) k++;
         step();
         cyc++;
      end
      bus.cfg_valid_i = 1'b0;
      check("cfg_beats", 32'(k), 32'd9);
   endtask

   // Stream n pixels with a fixed conv_ready stall pattern, optionally loading weights alongside.
   task automatic feed(input int n, input bit load, input logic [17:0] w, output int fired);
      int k;
      int cyc;
      bit rdy;
      k     = 0;
      cyc   = 0;
      fired = 0;
      while (fired < n && cyc < 200) begin
         rdy               = (cyc % 3) != 2;
         bus.pix_valid_i   = 1'b1;
         bus.conv_ready_i  = rdy;
         bus.cfg_valid_i   = load && (k < 9);
         bus.cfg_data_i    = (k < 9) ? w[k*2 +: 2] : 2'b00;
         #1;
         check("run_pix_ready", 32'(bus.pix_ready_o), 32'(rdy));
         check("run_conv_valid", 32'(bus.conv_valid_o), 32'd1);
         if (load && k < 9 && bus.cfg_ready_o) k++;
         if (rdy) fired++;
         step();
         cyc++;
      end
      bus.cfg_valid_i  = 1'b0;
      bus.conv_ready_i = 1'b1;
   endtask

   // One stalled monitor beat (must not count), then n real output fires.
   task automatic mon(input int n);
      bus.mon_valid_i = 1'b1;
      bus.mon_ready_i = 1'b0;
      step();
      repeat (n) begin
         bus.mon_ready_i = 1'b1;
         step();
      end
      bus.mon_valid_i = 1'b0;
      bus.mon_ready_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit");
   end

   initial begin
      wa = pattern(1'b0);
      wb = pattern(1'b1);
      bus.start_i      = 1'b0;
      bus.cfg_valid_i  = 1'b0;
      bus.cfg_data_i   = '0;
      bus.pix_valid_i  = 1'b1;
      bus.conv_ready_i = 1'b1;
      bus.mon_valid_i  = 1'b0;
      bus.mon_ready_i  = 1'b0;

      // Reset values
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_cfg_ready", 32'(bus.cfg_ready_o), 32'd1);
      check("rst_busy", 32'(bus.busy_o), 32'd0);
      check("rst_weights", 32'(bus.weights_o), 32'd0);
      check("rst_pix_ready", 32'(bus.pix_ready_o), 32'd0);
      check("rst_conv_valid", 32'(bus.conv_valid_o), 32'd0);
      check("rst_frame_done", 32'(bus.frame_done_o), 32'd0);
      check("rst_err", 32'(bus.err_o), 32'd0);
      rst_ni = 1'b1;
      step();
      check("idle_busy", 32'(bus.busy_o), 32'd0);
      check("idle_pix_ready", 32'(bus.pix_ready_o), 32'd0);

      // Start without weights: parks in ARM until a full bank arrives
      bus.start_i = 1'b1;
      step();
      bus.start_i = 1'b0;
      check("arm_busy", 32'(bus.busy_o), 32'd1);
      repeat (4) begin
         check("arm_pix_ready", 32'(bus.pix_ready_o), 32'd0);
         check("arm_conv_valid", 32'(bus.conv_valid_o), 32'd0);
         step();
      end
      load_weights(wa);
      check("full_cfg_ready", 32'(bus.cfg_ready_o), 32'd0);
      check("arm_still_pix", 32'(bus.pix_ready_o), 32'd0);
      check("arm_weights_old", 32'(bus.weights_o), 32'd0);
      step();
      check("run_weights_a", 32'(bus.weights_o), 32'(wa));
      check("run_cfg_ready", 32'(bus.cfg_ready_o), 32'd1);

      // Frame 1 with a mid-frame weight load
      feed(20, 1'b1, wb, sent);
      check("f1_sent", 32'(sent), 32'd20);
      check("f1_drain_pix", 32'(bus.pix_ready_o), 32'd0);
      check("f1_drain_conv", 32'(bus.conv_valid_o), 32'd0);
      check("f1_busy", 32'(bus.busy_o), 32'd1);
      check("f1_weights_hold", 32'(bus.weights_o), 32'(wa));
      check("f1_shadow_full", 32'(bus.cfg_ready_o), 32'd0);
      mon(5);
      check("f1_no_early_done", 32'(bus.frame_done_o), 32'd0);
      check("f1_busy5", 32'(bus.busy_o), 32'd1);
      mon(1);
      check("f1_done_wait", 32'(bus.frame_done_o), 32'd0);
      step();
      check("f1_done", 32'(bus.frame_done_o), 32'd1);
      check("f1_idle", 32'(bus.busy_o), 32'd0);
      check("f1_weights_after", 32'(bus.weights_o), 32'(wa));
      step();
      check("f1_done_once", 32'(bus.frame_done_o), 32'd0);

      // Frame 2 picks up the weights loaded during frame 1
      bus.start_i = 1'b1;
      step();
      bus.start_i = 1'b0;
      check("f2_arm_busy", 32'(bus.busy_o), 32'd1);
      check("f2_arm_pix", 32'(bus.pix_ready_o), 32'd0);
      check("f2_arm_weights", 32'(bus.weights_o), 32'(wa));
      step();
      check("f2_weights_b", 32'(bus.weights_o), 32'(wb));
      check("f2_cfg_ready", 32'(bus.cfg_ready_o), 32'd1);
      feed(20, 1'b0, wb, sent);
      check("f2_sent", 32'(sent), 32'd20);
      mon(5);
`ifdef CONV2D_CTRL_TIMEOUT_EN
      repeat (63) step();
      check("to_err_before", 32'(bus.err_o), 32'd0);
      check("to_busy_before", 32'(bus.busy_o), 32'd1);
      check("to_done_before", 32'(bus.frame_done_o), 32'd0);
      step();
      check("to_err", 32'(bus.err_o), 32'd1);
      check("to_done", 32'(bus.frame_done_o), 32'd1);
      check("to_idle", 32'(bus.busy_o), 32'd0);
      step();
      check("to_done_once", 32'(bus.frame_done_o), 32'd0);
      check("to_err_sticky", 32'(bus.err_o), 32'd1);
`else
      repeat (80) step();
      check("wait_err", 32'(bus.err_o), 32'd0);
      check("wait_busy", 32'(bus.busy_o), 32'd1);
      check("wait_done", 32'(bus.frame_done_o), 32'd0);
      mon(1);
      check("f2_done_wait", 32'(bus.frame_done_o), 32'd0);
      step();
      check("f2_done", 32'(bus.frame_done_o), 32'd1);
      check("f2_idle", 32'(bus.busy_o), 32'd0);
`endif

      // Frame 3 aborted by reset
      step();
      bus.start_i = 1'b1;
      step();
      bus.start_i = 1'b0;
      step();
      check("f3_weights", 32'(bus.weights_o), 32'(wb));
      feed(7, 1'b0, wb, sent);
      check("f3_sent", 32'(sent), 32'd7);
      rst_ni = 1'b0;
      #1;
      check("abort_busy", 32'(bus.busy_o), 32'd0);
      check("abort_weights", 32'(bus.weights_o), 32'd0);
      check("abort_cfg_ready", 32'(bus.cfg_ready_o), 32'd1);
      check("abort_pix_ready", 32'(bus.pix_ready_o), 32'd0);
      check("abort_err", 32'(bus.err_o), 32'd0);
      step();
      rst_ni = 1'b1;
      repeat (5) begin
         step();
         check("abort_no_done", 32'(bus.frame_done_o), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/conv2d_ctrl.md
# conv2d_ctrl

Frame sequencer and weight-bank controller for the `conv2d` streaming convolution block. It accepts kernel weights over a serial configuration stream into a shadow bank and swaps them into an active bank only at frame boundaries. It gates exactly one frame of pixels into `conv2d` per start command, then counts convolution outputs until the frame has fully drained. It sits between the camera pixel source and `conv2d`, and drives `conv2d`'s `weights_i`.

## Interface
- `LineWidthPx`, 160, pixels per line; must match `conv2d`.
- `LineCountPx`, 120, lines per frame; must match `conv2d`.
- `KernelWidth`, 3, kernel side length; must match `conv2d`.
- `WeightWidth`, 2, bits per signed weight.
- `DrainTimeout`, 64, maximum idle DRAIN cycles; used only with the macro below.
- `clk_i`  in  1  single clock; all state updates on its rising edge.
- `rst_ni`  in  1  reset, asynchronous and active-low.
- `start_i`  in  1  one-cycle frame start request.
- `cfg_valid_i` / `cfg_ready_o`  in/out  1  weight-stream handshake.
- `cfg_data_i`  in  WeightWidth  one weight per beat; index 0 (top-left, row-major) first.
- `pix_valid_i` / `pix_ready_o`  in/out  1  upstream pixel handshake.
- `conv_valid_o` / `conv_ready_i`  out/in  1  handshake toward `conv2d` input.
- `mon_valid_i` / `mon_ready_i`  in  1  snooped `conv2d` output handshake.
- `weights_o`  out  KernelArea×WeightWidth  active bank, row-major.
- `busy_o`  out  1  high when not in IDLE.
- `frame_done_o`  out  1  one-cycle pulse at frame completion.
- `err_o`  out  1  sticky drain-timeout flag.

## Operation
- Shadow bank: `cfg_ready_o = ~shadow_full`.
  - Each cfg fire writes `shadow[idx]` and increments `idx`.
  - At `idx == KernelArea-1` the fire sets `shadow_full` and wraps `idx` to 0.
- Active bank: copied from shadow, and `shadow_full` cleared, only on the ARM→RUN transition when `shadow_full` is set.
  - `active_valid` is set on the first copy.
  - `weights_o` never changes during RUN or DRAIN.
- FSM states:
  - IDLE: `start_i` → ARM. `start_i` is ignored in any other state.
  - ARM: when `active_valid | shadow_full` → RUN, performing the bank swap if `shadow_full`.
  - RUN: `conv_valid_o = pix_valid_i` and `pix_ready_o = conv_ready_i`, both combinational. `in_cnt` counts fires. The fire that brings `in_cnt` to `LineWidthPx*LineCountPx` moves to DRAIN.
  - DRAIN: `pix_ready_o = 0` and `conv_valid_o = 0`. When `out_cnt == (LineWidthPx-KernelWidth+1)*(LineCountPx-KernelWidth+1)` → IDLE, pulse `frame_done_o`, and clear both counters.
- Outside RUN, `pix_ready_o = 0` and `conv_valid_o = 0`.
- `out_cnt` increments on every `mon_valid_i & mon_ready_i` in RUN or DRAIN.
- Counter widths are `$clog2(count+1)` and must not wrap.
- Asserting `rst_ni` mid-frame aborts it: state returns to IDLE, banks, flags and counters clear, and no `frame_done_o` is produced.

## Timing
- Reset values: `cfg_ready_o = 1`; `pix_ready_o`, `conv_valid_o`, `busy_o`, `frame_done_o` and `err_o` are 0; `weights_o = 0`.
- `start_i` → ARM takes 1 cycle. ARM → RUN is at least 1 cycle.
- The last input fire moves the FSM to DRAIN on the next edge.
- `frame_done_o` is registered and high for exactly the first cycle back in IDLE.
- A cfg fire on the same edge as a bank swap cannot occur, because `cfg_ready_o` is 0 whenever `shadow_full` is set.
- A new weight set may load during RUN or DRAIN; it applies from the next frame.

## Configuration
- `CONV2D_CTRL_TIMEOUT_EN` defined:
  - A DRAIN watchdog counts cycles without an `out_cnt` increment.
  - Reaching `DrainTimeout` sets `err_o` (sticky until reset), forces IDLE and pulses `frame_done_o`.
- Undefined: `err_o` is tied to 0 and DRAIN waits indefinitely.

## Structure
- Package `conv2d_ctrl_pkg`:
  - state enum: IDLE, ARM, RUN, DRAIN.
  - count-width helper function.
- Sub-module `weight_bank`: shadow/active double buffer with write index, `shadow_full`, `active_valid` and a swap input.

## Test plan
Bench uses `LineWidthPx=5`, `LineCountPx=4`, `KernelWidth=3`: 20 inputs and 6 outputs per frame.
- Reset: hold `rst_ni=0`, then release → `cfg_ready_o=1`, `busy_o=0`, `weights_o=0`.
- Weight load: load weights 0..8 (values mod 4), then `start_i` → RUN after 2 cycles; `weights_o` shows the loaded values and `cfg_ready_o` returns to 1.
- Full frame: 20 pixels with random `conv_ready_i` stalls and 6 monitor fires → `pix_ready_o` drops after the 20th fire; `frame_done_o` pulses once after the 6th monitor fire.
- Mid-frame weight load: load new weights during RUN → `weights_o` unchanged until the next frame's ARM→RUN.
- Start without weights: `start_i` with no weights loaded → stays in ARM and `pix_ready_o=0` until 9 cfg beats complete, then RUN.
- Timeout (with `CONV2D_CTRL_TIMEOUT_EN`): give only 5 monitor fires → 64 cycles later `err_o=1`, `frame_done_o` pulses and the FSM is in IDLE.
